// File: rtl/decode_inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : decode_inst_queue
// Purpose  : DEPTH-entry instruction buffer between fetch and decode. Each
//            entry is pre-decoded at enqueue for branch/jump and tagged with
//            its delay-slot status; the head drives decode combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module decode_inst_queue #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int FLAG_W  = 3
) (
    input  logic                         Clk,
    input  logic                         Clr_n,
    // fetch side
    input  logic                         I_valid,
    output logic                         I_ready,
    input  logic [PC_W-1:0]              I_PC,
    input  logic [INSTR_W-1:0]           I_MipsInstr,
    input  logic [FLAG_W-1:0]            I_flags,
    // decode side
    output logic                         D_valid,
    input  logic                         D_ready,
    output logic [PC_W-1:0]              D_PC,
    output logic [INSTR_W-1:0]           D_MipsInstr,
    output logic [FLAG_W-1:0]            D_flags,
    output logic                         D_is_branch,
    output logic                         D_in_delayslot,
    output logic [PC_W-1:0]              D_EPC,
    // flush control
    input  logic                         exp_flush,
    input  logic                         br_flush,
    input  logic                         br_keep_head,
    output logic [$clog2(DEPTH+1)-1:0]   D_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PC_W-1:0]  c_FOUR = PC_W'(4);
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    // Entry storage
    logic [PC_W-1:0]    r_pc    [DEPTH];
    logic [INSTR_W-1:0] r_instr [DEPTH];
    logic [FLAG_W-1:0]  r_flags [DEPTH];
    logic               r_is_br [DEPTH];
    logic               r_ds    [DEPTH];

    logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_last_enq_branch;

    logic [PTR_W-1:0] w_rd_ptr_nxt, w_wr_ptr_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_last_nxt;
    logic             w_wen;
    logic             w_enq, w_deq;
    logic             w_is_branch;

    // Handshakes depend only on registered occupancy
    assign I_ready = (r_count != c_FULL);
    assign D_valid = (r_count != '0);
    assign w_enq   = I_valid & I_ready;
    assign w_deq   = D_valid & D_ready;

    // Branch/jump pre-decode only makes sense for 32-bit MIPS encodings
    generate
        if (INSTR_W == 32) begin : g_predecode
            logic [5:0] w_op;
            logic [4:0] w_rt;
            logic [5:0] w_funct;
            assign w_op    = I_MipsInstr[31:26];
            assign w_rt    = I_MipsInstr[20:16];
            assign w_funct = I_MipsInstr[5:0];

            // Classify the incoming instruction as branch/jump
            always_comb begin
                w_is_branch = 1'b0;
                case (w_op)
                    6'b000100, 6'b000101, 6'b000110, 6'b000111: w_is_branch = 1'b1;
                    6'b000010, 6'b000011:                       w_is_branch = 1'b1;
                    6'b000001: w_is_branch = (w_rt == 5'b00000) || (w_rt == 5'b00001) ||
                                             (w_rt == 5'b10000) || (w_rt == 5'b10001);
                    6'b000000: w_is_branch = (w_funct == 6'b001000) || (w_funct == 6'b001001);
                    default:   w_is_branch = 1'b0;
                endcase
            end
        end else begin : g_no_predecode
            assign w_is_branch = 1'b0;
        end
    endgenerate

    // Next-state pointers/count: exp_flush beats br_flush beats normal flow
    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr;
        w_wr_ptr_nxt = r_wr_ptr;
        w_count_nxt  = r_count;
        w_last_nxt   = r_last_enq_branch;
        w_wen        = 1'b0;
        if (exp_flush) begin
            w_wr_ptr_nxt = r_rd_ptr;
            w_count_nxt  = '0;
            w_last_nxt   = 1'b0;
        end else if (br_flush) begin
            // The redirect target is never a delay slot
            w_last_nxt = 1'b0;
            if (br_keep_head && (r_count != '0)) begin
                w_wr_ptr_nxt = r_rd_ptr + 1'b1;
                if (w_deq) begin
                    w_rd_ptr_nxt = r_rd_ptr + 1'b1;
                    w_count_nxt  = '0;
                end else begin
                    w_count_nxt  = c_ONE;
                end
            end else begin
                w_wr_ptr_nxt = r_rd_ptr;
                w_count_nxt  = '0;
            end
        end else begin
            if (w_enq) begin
                w_wen        = 1'b1;
                w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                w_last_nxt   = w_is_branch;
            end
            if (w_deq) begin
                w_rd_ptr_nxt = r_rd_ptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   w_count_nxt = r_count + 1'b1;
                2'b01:   w_count_nxt = r_count - 1'b1;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            r_rd_ptr          <= '0;
            r_wr_ptr          <= '0;
            r_count           <= '0;
            r_last_enq_branch <= 1'b0;
        end else begin
            r_rd_ptr          <= w_rd_ptr_nxt;
            r_wr_ptr          <= w_wr_ptr_nxt;
            r_count           <= w_count_nxt;
            r_last_enq_branch <= w_last_nxt;
        end
    end

    // Entry storage write; delay-slot tag comes from the previous enqueue
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
                r_flags[i] <= '0;
                r_is_br[i] <= 1'b0;
                r_ds[i]    <= 1'b0;
            end
        end else if (w_wen) begin
            r_pc[r_wr_ptr]    <= I_PC;
            r_instr[r_wr_ptr] <= I_MipsInstr;
            r_flags[r_wr_ptr] <= I_flags;
            r_is_br[r_wr_ptr] <= w_is_branch;
            r_ds[r_wr_ptr]    <= r_last_enq_branch;
        end
    end

    // Head entry presented combinationally to decode
    assign D_PC           = r_pc[r_rd_ptr];
    assign D_MipsInstr    = r_instr[r_rd_ptr];
    assign D_flags        = r_flags[r_rd_ptr];
    assign D_is_branch    = r_is_br[r_rd_ptr];
    assign D_in_delayslot = r_ds[r_rd_ptr];
    assign D_EPC          = r_ds[r_rd_ptr] ? (r_pc[r_rd_ptr] - c_FOUR) : r_pc[r_rd_ptr];
    assign D_count        = r_count;

endmodule
`default_nettype wire

// File: tb/tb_decode_inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_inst_queue
// Purpose  : Directed self-checking bench for decode_inst_queue (DEPTH = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_inst_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int IW    = 32;
    localparam int FW    = 3;
    localparam logic [31:0] c_NOP = 32'h0000_0000;

    logic          Clk;
    logic          Clr_n;
    logic          I_valid;
    logic          I_ready;
    logic [PC_W-1:0] I_PC;
    logic [IW-1:0] I_MipsInstr;
    logic [FW-1:0] I_flags;
    logic          D_valid;
    logic          D_ready;
    logic [PC_W-1:0] D_PC;
    logic [IW-1:0] D_MipsInstr;
    logic [FW-1:0] D_flags;
    logic          D_is_branch;
    logic          D_in_delayslot;
    logic [PC_W-1:0] D_EPC;
    logic          exp_flush;
    logic          br_flush;
    logic          br_keep_head;
    logic [2:0]    D_count;

    int n_cmp = 0;
    int n_err = 0;

    decode_inst_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(IW), .FLAG_W(FW)) u_dut (
        .Clk(Clk), .Clr_n(Clr_n),
        .I_valid(I_valid), .I_ready(I_ready), .I_PC(I_PC),
        .I_MipsInstr(I_MipsInstr), .I_flags(I_flags),
        .D_valid(D_valid), .D_ready(D_ready), .D_PC(D_PC),
        .D_MipsInstr(D_MipsInstr), .D_flags(D_flags),
        .D_is_branch(D_is_branch), .D_in_delayslot(D_in_delayslot), .D_EPC(D_EPC),
        .exp_flush(exp_flush), .br_flush(br_flush), .br_keep_head(br_keep_head),
        .D_count(D_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Single comparison point for the whole bench
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic enq(input logic [31:0] pc, input logic [31:0] instr, input logic [2:0] fl);
        I_valid = 1'b1; I_PC = pc; I_MipsInstr = instr; I_flags = fl;
        step();
        I_valid = 1'b0;
    endtask

    task automatic deq();
        D_ready = 1'b1;
        step();
        D_ready = 1'b0;
    endtask

    // Pre-decode vectors: instruction and expected branch classification
    logic [31:0] pd_instr [15];
    logic        pd_br    [15];

    int unsigned exp_q[$];
    int unsigned next_pc;
    int          popped;
    logic        exp_ds;
    logic        enq_f, deq_f;

    initial begin
        pd_instr = '{32'h1000_0003, 32'h1400_0000, 32'h1800_0000, 32'h1C00_0000,
                     32'h0400_0000, 32'h0401_0000, 32'h0410_0000, 32'h0411_0000,
                     32'h0402_0000, 32'h0800_0000, 32'h0C00_0000, 32'h03E0_0008,
                     32'h03E0_0009, 32'h0000_000A, 32'h2000_0000};
        pd_br    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                     1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        I_valid = 0; I_PC = '0; I_MipsInstr = '0; I_flags = '0;
        D_ready = 0; exp_flush = 0; br_flush = 0; br_keep_head = 0;
        Clr_n = 1'b1;
        #1 Clr_n = 1'b0;
        #2;
        // Reset state
        chk("rst_dvalid", D_valid, 0);
        chk("rst_count", D_count, 0);
        chk("rst_iready", I_ready, 1);
        chk("rst_dpc", D_PC, 0);
        chk("rst_epc", D_EPC, 0);
        step(); step();
        Clr_n = 1'b1;
        step();

        // Asynchronous reset mid-operation, last entry a branch
        enq(32'h10, c_NOP, 3'b0);
        enq(32'h14, c_NOP, 3'b0);
        enq(32'h18, 32'h1000_0003, 3'b0);
        chk("midrst_pre_count", D_count, 3);
        #2 Clr_n = 1'b0;
        #1;
        chk("midrst_dvalid", D_valid, 0);
        chk("midrst_count", D_count, 0);
        chk("midrst_iready", I_ready, 1);
        #1 Clr_n = 1'b1;
        enq(32'h40, c_NOP, 3'b0);
        chk("midrst_first_pc", D_PC, 32'h40);
        chk("midrst_first_ds", D_in_delayslot, 0);
        deq();
        chk("midrst_drained", D_count, 0);
        deq();  // dequeue while empty is ignored
        chk("underflow_count", D_count, 0);
        chk("underflow_dvalid", D_valid, 0);

        // Fill/wrap with D_ready toggling, against a reference queue
        next_pc = 32'h100;
        popped  = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            chk("wrap_count", D_count, exp_q.size());
            chk("wrap_iready", I_ready, exp_q.size() < DEPTH);
            if (exp_q.size() > 0) chk("wrap_head_pc", D_PC, exp_q[0]);
            I_valid     = (next_pc <= 32'h11C);
            I_PC        = next_pc;
            I_MipsInstr = c_NOP;
            I_flags     = '0;
            D_ready     = cyc[0];
            enq_f = I_valid && (exp_q.size() < DEPTH);
            deq_f = D_ready && (exp_q.size() > 0);
            step();
            if (deq_f) begin
                void'(exp_q.pop_front());
                popped++;
            end
            if (enq_f) begin
                exp_q.push_back(next_pc);
                next_pc += 4;
            end
        end
        I_valid = 0; D_ready = 0;
        chk("wrap_popped", popped, 8);
        chk("wrap_empty", D_count, 0);

        // Pre-decode table; each entry's delay-slot tag follows its predecessor
        exp_ds = 1'b0;
        for (int i = 0; i < 15; i++) begin
            enq(32'h800 + 32'(i * 4), pd_instr[i], 3'b0);
            chk($sformatf("pd_br_%0d", i), D_is_branch, pd_br[i]);
            chk($sformatf("pd_ds_%0d", i), D_in_delayslot, exp_ds);
            exp_ds = pd_br[i];
            deq();
        end

        // Delay slot tagging and EPC
        enq(32'h200, 32'h1000_0003, 3'b0);
        enq(32'h204, 32'h0085_1021, 3'b0);
        chk("ds_br_pc", D_PC, 32'h200);
        chk("ds_br_isbr", D_is_branch, 1);
        chk("ds_br_ds", D_in_delayslot, 0);
        chk("ds_br_epc", D_EPC, 32'h200);
        deq();
        chk("ds_slot_pc", D_PC, 32'h204);
        chk("ds_slot_ds", D_in_delayslot, 1);
        chk("ds_slot_isbr", D_is_branch, 0);
        chk("ds_slot_epc", D_EPC, 32'h200);
        deq();

        // EPC wraps modulo 2^PC_W
        enq(32'hFFFF_FFFC, 32'h1000_0003, 3'b0);
        enq(32'h0, c_NOP, 3'b0);
        deq();
        chk("epc_wrap", D_EPC, 32'hFFFF_FFFC);
        deq();

        // Branch flush keeping the delay slot, with a concurrent fetch
        enq(32'h300, 32'h03E0_0008, 3'b0);
        enq(32'h304, c_NOP, 3'b0);
        enq(32'h308, 32'h0800_0040, 3'b0);
        deq();
        chk("brk_pre_count", D_count, 2);
        br_flush = 1; br_keep_head = 1;
        I_valid = 1; I_PC = 32'h3F0; I_MipsInstr = c_NOP;
        step();
        br_flush = 0; br_keep_head = 0; I_valid = 0;
        chk("brk_count", D_count, 1);
        chk("brk_head_pc", D_PC, 32'h304);
        chk("brk_head_ds", D_in_delayslot, 1);
        chk("brk_head_epc", D_EPC, 32'h300);
        enq(32'h400, c_NOP, 3'b0);
        chk("brk_count2", D_count, 2);
        deq();
        chk("brk_target_pc", D_PC, 32'h400);
        chk("brk_target_ds", D_in_delayslot, 0);
        deq();

        // Branch flush without keep empties the queue
        enq(32'h480, c_NOP, 3'b0);
        enq(32'h484, c_NOP, 3'b0);
        br_flush = 1; br_keep_head = 0;
        step();
        br_flush = 0;
        chk("brnk_count", D_count, 0);
        chk("brnk_dvalid", D_valid, 0);

        // Exception flush overrides everything else
        enq(32'h600, 32'h1000_0003, 3'b0);
        enq(32'h604, c_NOP, 3'b0);
        enq(32'h608, 32'h1000_0003, 3'b0);
        chk("exp_pre_count", D_count, 3);
        exp_flush = 1; br_flush = 1; br_keep_head = 1; D_ready = 1;
        I_valid = 1; I_PC = 32'h6F0; I_MipsInstr = c_NOP;
        step();
        exp_flush = 0; br_flush = 0; br_keep_head = 0; D_ready = 0; I_valid = 0;
        chk("exp_count", D_count, 0);
        chk("exp_dvalid", D_valid, 0);
        chk("exp_iready", I_ready, 1);
        enq(32'h700, c_NOP, 3'b0);
        chk("exp_next_pc", D_PC, 32'h700);
        chk("exp_next_ds", D_in_delayslot, 0);
        deq();

        // Steady simultaneous enqueue/dequeue at count 2; flags pass through
        enq(32'h500, c_NOP, 3'b101);
        enq(32'h504, c_NOP, 3'b000);
        chk("sim_flags", D_flags, 3'b101);
        chk("sim_head0", D_PC, 32'h500);
        for (int i = 0; i < 10; i++) begin
            I_valid = 1; I_PC = 32'h508 + 32'(i * 4); I_MipsInstr = c_NOP; I_flags = '0;
            D_ready = 1;
            step();
            chk("sim_count", D_count, 2);
            chk("sim_head", D_PC, 32'h504 + 32'(i * 4));
        end
        I_valid = 0; D_ready = 0;
        deq(); deq();
        chk("sim_drained", D_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
